// File: rtl/button_if.sv
// Board push-button bundle: raw pins in, conditioned levels, pulses and system reset out.
// master = board/driver side, slave = conditioner side.
interface button_if #(
  parameter int NUM_BUTTONS = 3
);
  logic [NUM_BUTTONS-1:0] button_in;
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic                   sys_rst_n;

  modport master (
    output button_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  sys_rst_n
  );

  modport slave (
    input  button_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output sys_rst_n
  );
endinterface

// File: rtl/button_reset_conditioner.sv
// Synchronise/debounce board buttons and generate a stretched system reset.
// Ports: clk25, rst_n (async low), btn (button_if.slave: pins in; level/press/release/sys_rst_n out).
module button_reset_conditioner #(
  parameter int NUM_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int RESET_HOLD_CYCLES = 65536,
  parameter int RESET_BUTTON      = 0,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic    clk25,
  input  logic    rst_n,
  button_if.slave btn
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] IDLE =
    {NUM_BUTTONS{BUTTON_ACTIVE_LOW != 0}};

  typedef enum logic {
    HOLD,
    RUN
  } state_e;

  logic [NUM_BUTTONS-1:0] sync1_q;
  logic [NUM_BUTTONS-1:0] sync2_q;
  logic [NUM_BUTTONS-1:0] pressed;
  logic [NUM_BUTTONS-1:0] level_q;
  logic [NUM_BUTTONS-1:0] level_d;
  logic [NUM_BUTTONS-1:0] press_q;
  logic [NUM_BUTTONS-1:0] press_d;
  logic [NUM_BUTTONS-1:0] release_q;
  logic [NUM_BUTTONS-1:0] release_d;
  logic [NUM_BUTTONS-1:0][CW-1:0] cnt_q;
  logic [NUM_BUTTONS-1:0][CW-1:0] cnt_d;

  state_e        state_q;
  state_e        state_d;
  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hcnt_d;
  logic          srst_q;
  logic          srst_d;

  // XOR with the idle pin level gives 1 = pressed
  assign pressed = sync2_q ^ IDLE;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (pressed[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        level_d[i]   = pressed[i];
        cnt_d[i]     = '0;
        press_d[i]   = pressed[i];
        release_d[i] = ~pressed[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Reset FSM looks at the registered level, so a
  // press drops sys_rst_n one edge after btn_level rises
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    srst_d  = srst_q;
    unique case (state_q)
      HOLD: begin
        srst_d = 1'b0;
        if (level_q[RESET_BUTTON]) begin
          hcnt_d = '0;
        end else if (hcnt_q == HMAX) begin
          state_d = RUN;
          hcnt_d  = '0;
          srst_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      RUN: begin
        srst_d = 1'b1;
        if (level_q[RESET_BUTTON]) begin
          state_d = HOLD;
          hcnt_d  = '0;
          srst_d  = 1'b0;
        end
      end
      default: begin
        state_d = HOLD;
        hcnt_d  = '0;
        srst_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= IDLE;
      sync2_q   <= IDLE;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '0;
      state_q   <= HOLD;
      hcnt_q    <= '0;
      srst_q    <= 1'b0;
    end else begin
      sync1_q   <= btn.button_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      srst_q    <= srst_d;
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.sys_rst_n   = srst_q;

endmodule

// File: tb/tb_button_reset_conditioner.sv
// Bench for button_reset_conditioner: randomized and directed pin stimulus
// compared each cycle against a window-based reference model.
module tb_button_reset_conditioner;

  localparam int NB = 3;
  localparam int D  = 8;
  localparam int H  = 16;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;

  button_if #(.NUM_BUTTONS(NB)) bif ();

  button_reset_conditioner #(
    .NUM_BUTTONS      (NB),
    .DEBOUNCE_CYCLES  (D),
    .RESET_HOLD_CYCLES(H),
    .RESET_BUTTON     (0),
    .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .btn  (bif)
  );

  always #5 clk25 = ~clk25;

  // Reference model state
  logic [NB-1:0] m_level;
  logic [NB-1:0] m_press;
  logic [NB-1:0] m_rel;
  logic          m_sys;
  logic [NB-1:0] smp[$];
  int            n;
  int            last_block;
  int            checks;
  int            passed;

  // Pressed-polarity samples of the pin at each edge; a
  // change is accepted when the D samples that have reached
  // the debouncer (two edges of sync delay) all disagree
  // with the current level.
  task automatic model_reset();
    smp.delete();
    repeat (D + 2) smp.push_back('0);
    m_level    = '0;
    m_press    = '0;
    m_rel      = '0;
    m_sys      = 1'b0;
    last_block = n;
  endtask

  task automatic tick();
    logic [NB-1:0] lb;
    logic [NB-1:0] hi;
    logic [NB-1:0] lo;
    int sz;
    @(posedge clk25);
    n++;
    if (!rst_n) begin
      model_reset();
    end else begin
      lb = m_level;
      hi = '1;
      lo = '1;
      sz = smp.size();
      for (int k = sz - 1 - D; k <= sz - 2; k++) begin
        hi &= smp[k];
        lo &= ~smp[k];
      end
      m_press = hi & ~lb;
      m_rel   = lo & lb;
      m_level = (lb | m_press) & ~m_rel;
      smp.push_back(~bif.button_in);
      if (smp.size() > D + 4) void'(smp.pop_front());
      if (lb[0]) last_block = n;
      m_sys = ((n - last_block) >= H);
    end
    #1;
  endtask

  task automatic test_reset();
    bif.button_in = '1;
    rst_n = 1'b0;
    model_reset();
    #1;
    if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !== 10'b0) begin
      $display("FAIL reset_async got %b want 0",
        {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n});
    end else passed++;
    checks++;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bif.sys_rst_n !== (k >= H)) begin
        $display("FAIL powerup_sys edge %0d got %b want %b", k, bif.sys_rst_n, (k >= H));
      end else passed++;
      checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
          {m_level, m_press, m_rel, m_sys}) begin
        $display("FAIL powerup_model edge %0d got %b want %b", k,
          {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
          {m_level, m_press, m_rel, m_sys});
      end else passed++;
      checks++;
    end
  endtask

  task automatic test_clean_press();
    bif.button_in[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if ({bif.btn_level[1], bif.btn_press[1]} !== ((k == 10) ? 2'b11 : (k > 10) ? 2'b10 : 2'b00)) begin
        $display("FAIL press_edge edge %0d got %b%b", k, bif.btn_level[1], bif.btn_press[1]);
      end else passed++;
      checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
          {m_level, m_press, m_rel, m_sys}) begin
        $display("FAIL press_model edge %0d got %b want %b", k,
          {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
          {m_level, m_press, m_rel, m_sys});
      end else passed++;
      checks++;
    end
    bif.button_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if ({bif.btn_level[1], bif.btn_release[1], bif.sys_rst_n} !== ((k == 10) ? 3'b011 : (k > 10) ? 3'b001 : 3'b101)) begin
        $display("FAIL release_edge edge %0d got %b%b%b", k,
          bif.btn_level[1], bif.btn_release[1], bif.sys_rst_n);
      end else passed++;
      checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
          {m_level, m_press, m_rel, m_sys}) begin
        $display("FAIL release_model edge %0d got %b want %b", k,
          {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
          {m_level, m_press, m_rel, m_sys});
      end else passed++;
      checks++;
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0) bif.button_in[2] = ~bif.button_in[2];
      tick();
      if ({bif.btn_level[2], bif.btn_press[2], bif.btn_release[2]} !== 3'b000) begin
        $display("FAIL bounce_quiet cyc %0d got %b%b%b", c,
          bif.btn_level[2], bif.btn_press[2], bif.btn_release[2]);
      end else passed++;
      checks++;
    end
    bif.button_in[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bif.btn_level[2] !== (k >= 10)) begin
        $display("FAIL bounce_settle edge %0d got %b want %b", k, bif.btn_level[2], (k >= 10));
      end else passed++;
      checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
          {m_level, m_press, m_rel, m_sys}) begin
        $display("FAIL bounce_model edge %0d got %b want %b", k,
          {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
          {m_level, m_press, m_rel, m_sys});
      end else passed++;
      checks++;
    end
    bif.button_in[2] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset_button();
    logic want;
    bif.button_in[0] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 30) bif.button_in[0] = 1'b1;
      want = (k <= 10) || (k >= 56);
      if (bif.sys_rst_n !== want) begin
        $display("FAIL rstbtn_sys edge %0d got %b want %b", k, bif.sys_rst_n, want);
      end else passed++;
      checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
          {m_level, m_press, m_rel, m_sys}) begin
        $display("FAIL rstbtn_model edge %0d got %b want %b", k,
          {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
          {m_level, m_press, m_rel, m_sys});
      end else passed++;
      checks++;
    end
  endtask

  task automatic test_mid_reset();
    bif.button_in[1] = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !== 10'b0) begin
      $display("FAIL midreset_async got %b want 0",
        {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n});
    end else passed++;
    checks++;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bif.btn_press[1] !== (k == 10)) begin
        $display("FAIL midreset_press edge %0d got %b want %b", k, bif.btn_press[1], (k == 10));
      end else passed++;
      checks++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
          {m_level, m_press, m_rel, m_sys}) begin
        $display("FAIL midreset_model edge %0d got %b want %b", k,
          {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
          {m_level, m_press, m_rel, m_sys});
      end else passed++;
      checks++;
    end
    bif.button_in[1] = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_simultaneous();
    int np1;
    int np2;
    np1 = 0;
    np2 = 0;
    bif.button_in[2:1] = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick();
      np1 += int'(bif.btn_press[1]);
      np2 += int'(bif.btn_press[2]);
      if (k == 10) begin
        if (bif.btn_press !== 3'b110) begin
          $display("FAIL simul_press got %b want 110", bif.btn_press);
        end else passed++;
        checks++;
      end
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
          {m_level, m_press, m_rel, m_sys}) begin
        $display("FAIL simul_model edge %0d got %b want %b", k,
          {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
          {m_level, m_press, m_rel, m_sys});
      end else passed++;
      checks++;
    end
    if (np1 != 1 || np2 != 1) begin
      $display("FAIL simul_count got %0d,%0d want 1,1", np1, np2);
    end else passed++;
    checks++;
    bif.button_in[2:1] = 2'b11;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int hold;
    logic [NB-1:0] v;
    for (int seg = 0; seg < 60; seg++) begin
      v = NB'($urandom);
      v[0] = ($urandom_range(0, 5) != 0);
      bif.button_in = v;
      hold = $urandom_range(1, 14);
      for (int k = 0; k < hold; k++) begin
        tick();
        if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n} !==
            {m_level, m_press, m_rel, m_sys}) begin
          $display("FAIL random_model seg %0d got %b want %b", seg,
            {bif.btn_level, bif.btn_press, bif.btn_release, bif.sys_rst_n},
            {m_level, m_press, m_rel, m_sys});
        end else passed++;
        checks++;
        if ((bif.btn_press & bif.btn_release) !== '0) begin
          $display("FAIL random_excl got %b", bif.btn_press & bif.btn_release);
        end else passed++;
        checks++;
      end
    end
  endtask

  initial begin
    n      = 0;
    checks = 0;
    passed = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_reset_button();
    test_mid_reset();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_reset_conditioner.md
Name: button_reset_conditioner

Overview:
- Upstream conditioning stage for the Apple 1 core on the board top level.
- Synchronises and debounces the raw board push-buttons. Produces clean level, press-pulse and release-pulse outputs.
- Generates the system reset (sys_rst_n) that drives the apple1 core rst_n input. sys_rst_n is stretched at power-up and re-asserted while the designated reset button is held.
- Replaces the direct button-to-core reset connection.

Parameters:
- NUM_BUTTONS, 3: number of button inputs.
- DEBOUNCE_CYCLES, 250000: stable cycles required to accept a button change (10 ms at 25 MHz). Must be >= 2.
- RESET_HOLD_CYCLES, 65536: cycles sys_rst_n stays low after power-up or after reset-button release. Must be >= 2.
- RESET_BUTTON, 0: index of the button that forces system reset. Must be < NUM_BUTTONS.
- BUTTON_ACTIVE_LOW, 1: 1 = pin reads 0 when pressed.

Ports:
- clk25  in  1  system clock, 25 MHz.
- rst_n  in  1  reset, asynchronous, active-low (raw board/PLL reset).
- button_in  in  NUM_BUTTONS  raw asynchronous button pins.
- btn_level  out  NUM_BUTTONS  debounced state, 1 = pressed.
- btn_press  out  NUM_BUTTONS  one-cycle pulse when btn_level rises.
- btn_release  out  NUM_BUTTONS  one-cycle pulse when btn_level falls.
- sys_rst_n  out  1  conditioned system reset. Asserts asynchronously, deasserts synchronously.

Behaviour:
- Reset (rst_n=0), immediate and asynchronous:
  - btn_level=0, btn_press=0, btn_release=0, sys_rst_n=0.
  - All counters 0.
  - Synchronisers load the released pin level (BUTTON_ACTIVE_LOW ? 1 : 0).
  - Reset FSM goes to HOLD.
- Synchroniser: two flops per button. The second-stage output is converted to pressed polarity, giving p[i].
- Debounce, per button and fully independent. Counter width is clog2(DEBOUNCE_CYCLES+1).
  - p[i]==btn_level[i]: counter <= 0.
  - p[i]!=btn_level[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - p[i]!=btn_level[i] and counter == DEBOUNCE_CYCLES-1: btn_level[i] <= p[i]; counter <= 0; btn_press[i] or btn_release[i] <= 1 for exactly one cycle, aligned with the btn_level change.
  - Any bounce back to the current level restarts the count.
  - Latency: btn_level changes on rising edge 2+DEBOUNCE_CYCLES, counting the first edge that samples the new pin value as edge 1.
- Pulses: btn_press and btn_release are never both high for the same bit. Several bits may pulse in the same cycle.
- Reset FSM, states HOLD and RUN, with a hold counter of width clog2(RESET_HOLD_CYCLES).
  - HOLD: sys_rst_n=0.
    - If btn_level[RESET_BUTTON]=1: counter held at 0.
    - Else if counter == RESET_HOLD_CYCLES-1: go to RUN, sys_rst_n <= 1.
    - Else counter increments.
  - RUN: sys_rst_n=1.
    - If btn_level[RESET_BUTTON]=1: go to HOLD, counter <= 0, sys_rst_n <= 0 on the next edge (one cycle after btn_level rises).
- Power-up: sys_rst_n rises on the RESET_HOLD_CYCLES-th edge after rst_n deasserts, provided the reset button is idle.
- Reset button: sys_rst_n rises on the RESET_HOLD_CYCLES-th edge after the edge on which btn_level[RESET_BUTTON] falls.
- The reset button still produces its btn_level, btn_press and btn_release outputs normally.
- rst_n asserted mid-debounce or mid-hold: all progress is discarded. After release, a full fresh debounce and hold is required.
- sys_rst_n is a registered output with no combinational path from button_in.

Test Plan (DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=16, active-low pins):
1. rst_n low 3 cycles then high, buttons idle 1 -> sys_rst_n=0 until the 16th edge after rst_n rises, then 1. btn_level=000, no pulses.
2. button_in[1] 1->0 cleanly -> btn_level[1] rises on edge 10 with btn_press[1] high for exactly that cycle. Pin back to 1 -> btn_level[1] falls 10 edges later with btn_release[1] one-cycle pulse. sys_rst_n stays 1.
3. button_in[2] toggles every 5 cycles for 40 cycles, then holds 0 -> no pulses and btn_level[2]=0 while toggling. btn_level[2] rises 10 edges after the last transition.
4. In RUN, button_in[0] held 0 for 30 cycles -> sys_rst_n falls one edge after btn_level[0] rises and stays 0 while pressed. It rises on the 16th edge after btn_level[0] falls.
5. button_in[1] pressed, rst_n pulsed low at count 5 -> all outputs 0 immediately. After rst_n release with the pin still 0, btn_press[1] fires 10 edges later, not earlier.
6. Buttons 1 and 2 pressed on the same edge -> btn_press=3'b110 in one cycle, single pulse each.
